// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single data-memory port between the pipeline MEM
//               stage (core) and an external loader/debug master (ext).
//               Each access goes IDLE -> ACCESS -> RESP -> IDLE. The read
//               data is registered per port, and a one-cycle ack pulse is
//               returned in the IDLE cycle after RESP.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               core_* (req/we/addr/wdata/funct3 in; ack/rdata/stall out)
//               ext_*  (req/we/addr/wdata/funct3/lock in; ack/rdata out)
//               mem_*  (rd/wr/addr/wdata/funct3 out; rdata in)
//               busy, owner           - FSM activity and current owner
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_funct3,
  output logic                  core_ack,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_stall,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [DM_ADDRESS-1:0] ext_addr,
  input  logic [DATA_W-1:0]     ext_wdata,
  input  logic [2:0]            ext_funct3,
  input  logic                  ext_lock,
  output logic                  ext_ack,
  output logic [DATA_W-1:0]     ext_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy,
  output logic                  owner
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q;
  logic                  owner_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [2:0]            funct3_q;
  logic                  core_ack_q, ext_ack_q;
  logic [DATA_W-1:0]     core_rdata_q, ext_rdata_q;

  // A request is not eligible in the cycle its own ack is high: a req held
  // through the ack is treated as a fresh request from the next cycle.
  logic core_elig, ext_elig, grant_core, grant_ext, grant;

  assign core_elig  = core_req & ~core_ack_q;
  assign ext_elig   = ext_req  & ~ext_ack_q;
  // Lock reserves the memory for ext even when ext is idle; otherwise the
  // core has fixed priority.
  assign grant_core = core_elig & ~ext_lock;
  assign grant_ext  = ext_elig & (ext_lock | ~core_elig);
  assign grant      = (state_q == S_IDLE) & (grant_core | grant_ext);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant_core | grant_ext) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q         <= 1'b0;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
      core_ack_q   <= 1'b0;
      ext_ack_q    <= 1'b0;
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
    end else begin
      core_ack_q <= 1'b0;
      ext_ack_q  <= 1'b0;
      if (grant) begin
        // The command registers double as the memory address/data/size
        // outputs, so those outputs hold their values outside ACCESS.
        owner_q  <= ~grant_core;
        we_q     <= grant_core ? core_we     : ext_we;
        addr_q   <= grant_core ? core_addr   : ext_addr;
        wdata_q  <= grant_core ? core_wdata  : ext_wdata;
        funct3_q <= grant_core ? core_funct3 : ext_funct3;
      end
      if (state_q == S_RESP) begin
        if (owner_q) begin
          ext_ack_q <= 1'b1;
          if (!we_q) ext_rdata_q <= mem_rdata;
        end else begin
          core_ack_q <= 1'b1;
          if (!we_q) core_rdata_q <= mem_rdata;
        end
      end
    end
  end

  // Strobes are gated by reset so an in-flight access never touches memory
  // in a reset cycle.
  assign mem_rd     = (state_q == S_ACCESS) & ~we_q & ~reset;
  assign mem_wr     = (state_q == S_ACCESS) &  we_q & ~reset;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_funct3 = funct3_q;

  assign core_ack   = core_ack_q;
  assign core_rdata = core_rdata_q;
  assign core_stall = core_req & ~core_ack_q;
  assign ext_ack    = ext_ack_q;
  assign ext_rdata  = ext_rdata_q;
  assign busy       = (state_q != S_IDLE);
  assign owner      = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. A behavioural memory
//               serves the DUT; requester tasks push expected read data into
//               per-port queues, and a monitor pops and compares on each ack.
//               Directed scenarios check timing; a random phase exercises
//               both ports concurrently on disjoint address halves.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we, ext_req, ext_we, ext_lock;
  logic [8:0]  core_addr, ext_addr, mem_addr;
  logic [31:0] core_wdata, ext_wdata, core_rdata, ext_rdata;
  logic [31:0] mem_wdata, mem_rdata;
  logic [2:0]  core_funct3, ext_funct3, mem_funct3;
  logic        core_ack, core_stall, ext_ack, mem_rd, mem_wr, busy, owner;

  always #5 clk = ~clk;

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_funct3(core_funct3),
    .core_ack(core_ack), .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_funct3(ext_funct3), .ext_lock(ext_lock),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return 32'(i) * 32'h9E3779B9 + 32'h1234_0000;
  endfunction

  // Behavioural data memory: write at end of strobe cycle, read data the
  // following cycle.
  logic        mem_load;
  logic [31:0] dmem [0:511];
  logic [31:0] mem_rdata_r;
  assign mem_rdata = mem_rdata_r;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 512; i++) dmem[i] <= init_word(i);
      mem_rdata_r <= 32'h0;
    end else begin
      if (mem_wr) dmem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata_r <= dmem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: architectural memory image plus last read value per port.
  logic [31:0] ref_mem [0:511];
  logic [31:0] core_last, ext_last;
  logic [31:0] core_q[$];
  logic [31:0] ext_q[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  logic [31:0] mon_exp;
  always @(negedge clk) begin
    if (!reset) begin
      if (core_ack) begin
        if (core_q.size() == 0) chk("core_ack unexpected", {31'b0, core_ack}, 32'd0);
        else begin
          mon_exp = core_q.pop_front();
          chk("core_rdata", core_rdata, mon_exp);
        end
      end
      if (ext_ack) begin
        if (ext_q.size() == 0) chk("ext_ack unexpected", {31'b0, ext_ack}, 32'd0);
        else begin
          mon_exp = ext_q.pop_front();
          chk("ext_rdata", ext_rdata, mon_exp);
        end
      end
    end
  end

  // Issue one core access at the current cycle (called just after a rising
  // edge); returns the cycle in which the ack was seen.
  task automatic core_txn(input logic we, input logic [8:0] a, input logic [31:0] d,
                          input logic [2:0] f3, input bit hold, output int ack_cyc);
    core_we = we; core_addr = a; core_wdata = d; core_funct3 = f3; core_req = 1'b1;
    if (we) ref_mem[a] = d;
    else core_last = ref_mem[a];
    core_q.push_back(core_last);
    ack_cyc = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (core_ack) begin ack_cyc = cyc; break; end
    end
    if (ack_cyc < 0) chk("core_ack timeout", {31'b0, core_ack}, 32'd1);
    @(posedge clk); #1;
    if (!hold) core_req = 1'b0;
  endtask

  task automatic ext_txn(input logic we, input logic [8:0] a, input logic [31:0] d,
                         input logic [2:0] f3, input bit hold, output int ack_cyc);
    ext_we = we; ext_addr = a; ext_wdata = d; ext_funct3 = f3; ext_req = 1'b1;
    if (we) ref_mem[a] = d;
    else ext_last = ref_mem[a];
    ext_q.push_back(ext_last);
    ack_cyc = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ext_ack) begin ack_cyc = cyc; break; end
    end
    if (ack_cyc < 0) chk("ext_ack timeout", {31'b0, ext_ack}, 32'd1);
    @(posedge clk); #1;
    if (!hold) ext_req = 1'b0;
  endtask

  task automatic core_rand(input int n);
    int gap, ac;
    bit hold;
    for (int i = 0; i < n; i++) begin
      hold = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      core_txn(1'($urandom_range(0, 1)), 9'($urandom_range(0, 255)), $urandom,
               3'($urandom_range(0, 7)), hold, ac);
      if (!hold) begin
        gap = $urandom_range(0, 3);
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
      end
    end
  endtask

  task automatic ext_rand(input int n);
    int gap, ac;
    bit hold;
    for (int i = 0; i < n; i++) begin
      hold = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      ext_txn(1'($urandom_range(0, 1)), 9'($urandom_range(256, 511)), $urandom,
              3'($urandom_range(0, 7)), hold, ac);
      if (!hold) begin
        gap = $urandom_range(0, 3);
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
      end
    end
  endtask

  int t0, tl, ca, ea, a1, a2, a3;
  logic [31:0] old_word;

  initial begin
    reset = 1'b1; mem_load = 1'b1; ext_lock = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_funct3 = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0; ext_funct3 = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
    core_last = 32'h0; ext_last = 32'h0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; mem_load = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset owner", {31'b0, owner}, 32'd0);
    chk("reset acks", {30'b0, core_ack, ext_ack}, 32'd0);
    chk("reset core_rdata", core_rdata, 32'h0);
    chk("reset ext_rdata", ext_rdata, 32'h0);
    chk("reset strobes", {30'b0, mem_rd, mem_wr}, 32'd0);
    chk("reset mem_addr", {23'b0, mem_addr}, 32'd0);
    @(posedge clk); #1;

    // 1: core read alone
    t0 = cyc;
    fork
      core_txn(1'b0, 9'h010, 32'h0, 3'b100, 1'b0, ca);
      begin
        @(negedge clk);
        chk("t1 c0 stall", {31'b0, core_stall}, 32'd1);
        chk("t1 c0 busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        chk("t1 c1 mem_rd", {31'b0, mem_rd}, 32'd1);
        chk("t1 c1 mem_addr", {23'b0, mem_addr}, 32'h010);
        chk("t1 c1 mem_funct3", {29'b0, mem_funct3}, 32'd4);
        chk("t1 c1 owner", {31'b0, owner}, 32'd0);
        @(negedge clk);
        chk("t1 c2 mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("t1 c2 stall", {31'b0, core_stall}, 32'd1);
        @(negedge clk);
        chk("t1 c3 ack", {31'b0, core_ack}, 32'd1);
        chk("t1 c3 stall", {31'b0, core_stall}, 32'd0);
      end
    join
    chk("t1 latency", 32'(ca - t0), 32'd3);

    // 2: simultaneous requests, core wins then ext
    t0 = cyc;
    fork
      core_txn(1'b1, 9'h020, 32'h55, 3'b010, 1'b0, ca);
      ext_txn(1'b0, 9'h024, 32'h0, 3'b010, 1'b0, ea);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("t2 c1 mem_wr", {31'b0, mem_wr}, 32'd1);
        chk("t2 c1 mem_wdata", mem_wdata, 32'h55);
        chk("t2 c1 owner", {31'b0, owner}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t2 c4 mem_rd", {31'b0, mem_rd}, 32'd1);
        chk("t2 c4 mem_addr", {23'b0, mem_addr}, 32'h024);
        chk("t2 c4 owner", {31'b0, owner}, 32'd1);
        @(negedge clk);
        chk("t2 c5 owner busy", {30'b0, owner, busy}, 32'd3);
      end
    join
    chk("t2 core latency", 32'(ca - t0), 32'd3);
    chk("t2 ext latency", 32'(ea - t0), 32'd6);

    // 3: lock burst of three ext writes while core waits
    t0 = cyc; ext_lock = 1'b1;
    fork
      core_txn(1'b0, 9'h0C0, 32'h0, 3'b010, 1'b0, ca);
      begin
        ext_txn(1'b1, 9'h100, 32'hA1A1_0001, 3'b010, 1'b1, a1);
        ext_txn(1'b1, 9'h104, 32'hA1A1_0002, 3'b010, 1'b1, a2);
        ext_txn(1'b1, 9'h108, 32'hA1A1_0003, 3'b010, 1'b0, a3);
        @(negedge clk);
        chk("t3 locked idle busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        ext_lock = 1'b0; tl = cyc;
      end
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        chk("t3 core_stall held", {31'b0, core_stall}, 32'd1);
      end
    join
    chk("t3 ack1", 32'(a1 - t0), 32'd3);
    chk("t3 ack2", 32'(a2 - t0), 32'd7);
    chk("t3 ack3", 32'(a3 - t0), 32'd11);
    chk("t3 core after unlock", 32'(ca - tl), 32'd3);
    chk("t3 memory word", dmem[9'h108], 32'hA1A1_0003);

    // 4: lock with no ext request starves the core until released
    t0 = cyc; ext_lock = 1'b1;
    fork
      core_txn(1'b0, 9'h0C4, 32'h0, 3'b000, 1'b0, ca);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("t4 busy low", {31'b0, busy}, 32'd0);
          chk("t4 stall high", {31'b0, core_stall}, 32'd1);
        end
        @(posedge clk); #1;
        ext_lock = 1'b0;
      end
    join
    chk("t4 core ack cycle", 32'(ca - t0), 32'd8);

    // 5: reset during ACCESS of a core write
    old_word = dmem[9'h030];
    core_we = 1'b1; core_addr = 9'h030; core_wdata = 32'hBAD0BAD0; core_funct3 = 3'b010;
    core_req = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; core_req = 1'b0;
    @(negedge clk);
    chk("t5 mem_wr gated", {31'b0, mem_wr}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; core_last = 32'h0; ext_last = 32'h0;
    @(negedge clk);
    chk("t5 busy after reset", {31'b0, busy}, 32'd0);
    chk("t5 core_rdata cleared", core_rdata, 32'h0);
    repeat (3) @(negedge clk);
    chk("t5 memory unchanged", dmem[9'h030], old_word);
    @(posedge clk); #1;

    // 6: write then read of the same word with req held across the ack
    core_txn(1'b1, 9'h040, 32'hCAFEF00D, 3'b010, 1'b1, a1);
    fork
      core_txn(1'b0, 9'h040, 32'h0, 3'b010, 1'b0, a2);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("t6 second access", {31'b0, mem_rd}, 32'd1);
        chk("t6 second addr", {23'b0, mem_addr}, 32'h040);
      end
    join
    chk("t6 back-to-back spacing", 32'(a2 - a1), 32'd4);

    // Random concurrent traffic
    fork
      core_rand(40);
      ext_rand(40);
    join
    repeat (4) @(posedge clk);
    #1;
    chk("core queue drained", 32'(core_q.size()), 32'd0);
    chk("ext queue drained", 32'(ext_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
